multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I core: steps each instruction through fetch, decode,
//  execute, memory and writeback. Drives IR/PC/regfile/CSR write strobes and the imem/dmem
//  request handshakes from the decoder's s_* flags and itype.
//  Bus timeouts and illegal opcodes become a trap that redirects the PC to the trap vector.
//  Counts retired instructions.
// PARAMETERS
//  BUS_TIMEOUT  16  max cycles a request waits for *_ready before access-fault trap (>=2)
// PORTS
//  clock         in   1   core clock
//  reset         in   1   asynchronous, active-high reset
//  imem_req      out  1   instruction fetch request, held until imem_ready
//  imem_ready    in   1   fetch data valid this cycle
//  dmem_req      out  1   data access request, held until dmem_ready
//  dmem_we       out  1   1=store, 0=load; valid while dmem_req
//  dmem_ready    in   1   data access complete this cycle
//  itype         in   3   decoder instruction type; 0 = unrecognised opcode
//  rd            in   5   decoder destination register
//  s_load        in   1   decoder flag: legal load
//  s_store       in   1   decoder flag: legal store
//  s_jump        in   1   decoder flag: JAL/JALR
//  s_branch      in   1   decoder flag: legal branch
//  s_csr         in   1   decoder flag: CSR access
//  br_taken      in   1   branch condition from ALU; sampled in S_EXEC
//  ir_we         out  1   latch instruction register
//  pc_we         out  1   update PC
//  pc_sel        out  2   0=pc+4, 1=ALU target, 2=trap vector
//  rf_we         out  1   regfile write enable
//  csr_we        out  1   CSR write enable
//  trap_valid    out  1   one-cycle pulse on trap entry
//  trap_cause    out  4   mcause code; valid while trap_valid
//  instret       out  64  retired-instruction counter
//  state         out  3   current FSM state (debug)
// BEHAVIOUR
//  - States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6. Reset state IDLE.
//  - Reset value of every output is 0. Reset mid-operation aborts: imem_req/dmem_req drop at once.
//  - Reset clears the timeout counter, instret and the latched cause.
//  - IDLE: after 1 cycle, go to FETCH.
//  - FETCH: imem_req=1. On imem_ready: ir_we=1 that cycle, go to DECODE.
//  - DECODE: exactly 1 cycle, no strobes. itype==0 -> TRAP with cause 2; else go to EXEC.
//  - EXEC:
//     s_load|s_store -> MEM.
//     s_branch -> pc_we=1, pc_sel=br_taken?1:0, retire, go to FETCH.
//     otherwise -> WB.
//  - MEM: dmem_req=1, dmem_we=s_store. On dmem_ready:
//     store -> pc_we=1, pc_sel=0, retire, go to FETCH.
//     load -> WB.
//  - WB: rf_we=(rd!=0)&!s_store; csr_we=s_csr; pc_we=1, pc_sel=s_jump?1:0; retire; go to FETCH.
//  - Timeout counter: cleared on entry to FETCH/MEM; increments each cycle the request waits.
//    On reaching BUS_TIMEOUT-1 with no ready -> TRAP.
//    Causes: 1 = fetch, 5 = load, 7 = store.
//    Ready and timeout in the same cycle: ready wins.
//  - TRAP: 1 cycle; trap_valid=1, trap_cause=latched cause, pc_we=1, pc_sel=2; no retire;
//    go to FETCH.
//  - Retire: instret +1 in the retiring cycle; wraps 2^64-1 -> 0.
//  - Strobes are Moore/Mealy combinational from state + inputs, each asserted at most 1 cycle
//    per instruction. Requests are the exception: they stay high continuously until
//    ready/timeout.
//  - Latency with zero-wait memories:
//    branch 3 cycles (FETCH, DECODE, EXEC), ALU/jump 4, store 4, load 5.
// TESTING
//  1. ADDI x1 (rd=1, itype I), ready in 1st cycle
//     -> FETCH,DECODE,EXEC,WB. rf_we and pc_we(sel 0) in WB; instret 0->1.
//  2. Load with dmem_ready after 3 waits
//     -> dmem_req high 4 cycles, dmem_we=0; WB rf_we=1; total 8 cycles.
//  3. Store, then BEQ with br_taken=1
//     -> store: dmem_we=1, no rf_we. Branch: pc_sel=1 in EXEC, no rf_we; instret +2.
//  4. imem_ready never asserted (BUS_TIMEOUT=16)
//     -> TRAP after 16 FETCH cycles; trap_valid=1, cause=1, pc_sel=2; instret unchanged.
//  5. itype=0 at DECODE -> TRAP cause=2 next cycle, then FETCH.
//     Same test: JAL with rd=0 -> WB pc_sel=1, rf_we=0.
//  6. Assert reset during MEM with dmem_req=1
//     -> dmem_req=0 same cycle, state=IDLE, instret=0; FETCH resumes 1 cycle after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with bus-timeout and
// illegal-opcode traps, combinational strobes, and a 64-bit retire counter.
module multicycle_ctrl #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic [2:0]  itype,
  input  logic [4:0]  rd,
  input  logic        s_load,
  input  logic        s_store,
  input  logic        s_jump,
  input  logic        s_branch,
  input  logic        s_csr,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic        csr_we,
  output logic        trap_valid,
  output logic [3:0]  trap_cause,
  output logic [63:0] instret,
  output logic [2:0]  state
);

  localparam int TW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic [3:0]    cause_q, cause_d;
  logic          retire;
  logic          timeout;

  // The wait counter reaches BUS_TIMEOUT-1 on the BUS_TIMEOUT-th waiting cycle.
  assign timeout = (tmo_q == TW'(BUS_TIMEOUT - 1));
  assign state   = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      cause_q <= '0;
      instret <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) instret <= instret + 64'd1;
      // Any state change restarts the count, so entering FETCH/MEM always starts at 0.
      if (state_d != state_q)
        tmo_q <= '0;
      else if (state_q == S_FETCH || state_q == S_MEM)
        tmo_q <= tmo_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    rf_we      = 1'b0;
    csr_we     = 1'b0;
    trap_valid = 1'b0;
    trap_cause = 4'd0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          cause_d = 4'd1;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        if (itype == 3'd0) begin
          cause_d = 4'd2;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (s_load || s_store) begin
          state_d = S_MEM;
        end else if (s_branch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = s_store;
        if (dmem_ready) begin
          if (s_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          cause_d = s_store ? 4'd7 : 4'd5;
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        rf_we   = (rd != 5'd0) && !s_store;
        csr_we  = s_csr;
        pc_we   = 1'b1;
        pc_sel  = s_jump ? 2'd1 : 2'd0;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap_valid = 1'b1;
        trap_cause = cause_q;
        pc_we      = 1'b1;
        pc_sel     = 2'd2;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
